// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the multiplexed seven-segment display
// controller: the scan FSM state encoding, the "everything dark" patterns
// and the active-low hex glyph table used by the nibble decoder.
// Ports: none (package).
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  // Scan states: idle (dark), lighting one digit, or the anti-ghosting gap
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GHOST = 2'd2
  } state_t;

  // Segment and anode patterns that leave the display fully dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low glyphs {g,f,e,d,c,b,a}; element 0 is the glyph for hex 0
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational decoder from a 4-bit hex nibble to active-low segments.
// Ports:
//   i_nibble  in   4  hex value 0..F
//   o_segs    out  7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  // Straight table lookup; the glyph shapes live in the package
  assign o_segs = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_display_ctrl
// Scans a 4-digit multiplexed seven-segment display: each digit is lit for
// CLK_DIV cycles followed by GHOST_CYCLES of all-dark anti-ghosting gap.
// New values arrive through a valid/ready handshake into a one-entry pending
// buffer that is committed only at frame boundaries (or straight away while
// idle), so a displayed frame never mixes old and new digits.
// Ports:
//   i_clk         in   1   system clock
//   i_reset       in   1   asynchronous active-high reset
//   i_enable      in   1   1 = scan, 0 = all digits dark
//   i_value_in    in   16  four hex nibbles, [3:0] is digit 0 (rightmost)
//   i_load_valid  in   1   value offered
//   o_load_ready  out  1   pending buffer empty
//   i_dp_in       in   4   decimal point per digit (1 = lit)
//   i_blank_lz    in   1   1 = suppress leading zeros
//   o_anode       out  4   active-low one-hot digit select
//   o_segs        out  7   active-low segments {g,f,e,d,c,b,a}
//   o_dp          out  1   active-low decimal point
//   o_frame_done  out  1   pulse on the last gap cycle of digit 3
// ---------------------------------------------------------------------------
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int GHOST_CYCLES = 16
)(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_value_in,
  input  logic        i_load_valid,
  output logic        o_load_ready,
  input  logic [3:0]  i_dp_in,
  input  logic        i_blank_lz,
  output logic [3:0]  o_anode,
  output logic [6:0]  o_segs,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int MAX_CNT = (CLK_DIV > GHOST_CYCLES) ? CLK_DIV : GHOST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);

  state_t             r_state, w_nextState;
  logic [1:0]         r_digit, w_nextDigit;
  logic [CNT_W-1:0]   r_cnt, w_nextCnt;
  logic [15:0]        r_display, w_nextDisplay, r_pending, w_nextPending;
  logic [3:0]         r_dpReg, w_nextDpReg, r_pendDp, w_nextPendDp;
  logic               r_pendFull, w_nextPendFull;
  logic               w_commit, w_accept;
  logic [15:0]        w_shifted;
  logic [6:0]         w_glyph;
  logic               w_dark;
  logic [3:0]         w_anode;
  logic [6:0]         w_segs;
  logic               w_dp;
  logic               w_frameDone;

  // Scan sequencing: dropping enable always parks the scan at digit 0 so a
  // re-enable restarts the frame cleanly; otherwise walk SHOW -> GHOST and
  // advance the digit at the end of each gap.
  always_comb begin
    w_nextState = r_state;
    w_nextDigit = r_digit;
    w_nextCnt   = r_cnt + CNT_W'(1);
    if (!i_enable) begin
      w_nextState = IDLE;
      w_nextDigit = 2'd0;
      w_nextCnt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = SHOW;
          w_nextDigit = 2'd0;
          w_nextCnt   = '0;
        end
        SHOW: begin
          if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
            w_nextState = GHOST;
            w_nextCnt   = '0;
          end
        end
        GHOST: begin
          if (r_cnt == CNT_W'(GHOST_CYCLES - 1)) begin
            w_nextState = SHOW;
            w_nextDigit = r_digit + 2'd1;
            w_nextCnt   = '0;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextDigit = 2'd0;
          w_nextCnt   = '0;
        end
      endcase
    end
  end

  // Pending buffer: a commit moves pending into the display register while
  // idle or on the frame_done cycle. A load arriving in the same cycle as a
  // commit is still taken because the slot is being vacated, so the buffer
  // stays full with the newer value.
  always_comb begin
    w_commit       = r_pendFull && ((r_state == IDLE) || o_frame_done);
    w_accept       = i_load_valid && (!r_pendFull || w_commit);
    w_nextDisplay  = r_display;
    w_nextDpReg    = r_dpReg;
    w_nextPending  = r_pending;
    w_nextPendDp   = r_pendDp;
    w_nextPendFull = r_pendFull;
    if (w_commit) begin
      w_nextDisplay  = r_pending;
      w_nextDpReg    = r_pendDp;
      w_nextPendFull = 1'b0;
    end
    if (w_accept) begin
      w_nextPending  = i_value_in;
      w_nextPendDp   = i_dp_in;
      w_nextPendFull = 1'b1;
    end
  end

  // The nibble for the upcoming digit sits at the bottom of the shifted
  // display word; if the whole shifted word is zero then this digit and all
  // higher ones are zero, which is exactly the leading-zero condition.
  assign w_shifted = w_nextDisplay >> {w_nextDigit, 2'b00};
  assign w_dark    = i_blank_lz && (w_nextDigit != 2'd0) && (w_shifted == 16'h0000);

  hex_to_seg u_hexToSeg (
    .i_nibble (w_shifted[3:0]),
    .o_segs   (w_glyph)
  );

  // Output values are built from the next-cycle state so that the registered
  // outputs line up exactly with the state register they describe.
  always_comb begin
    w_anode     = ANODE_OFF;
    w_segs      = SEG_BLANK;
    w_dp        = 1'b1;
    w_frameDone = (w_nextState == GHOST) && (w_nextDigit == 2'd3) &&
                  (w_nextCnt == CNT_W'(GHOST_CYCLES - 1));
    if ((w_nextState == SHOW) && !w_dark) begin
      w_anode = ~(4'b0001 << w_nextDigit);
      w_segs  = w_glyph;
      w_dp    = ~w_nextDpReg[w_nextDigit];
    end
  end

  // All state and outputs, with reset forcing the display dark immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_digit      <= 2'd0;
      r_cnt        <= '0;
      r_display    <= '0;
      r_dpReg      <= '0;
      r_pending    <= '0;
      r_pendDp     <= '0;
      r_pendFull   <= 1'b0;
      o_anode      <= ANODE_OFF;
      o_segs       <= SEG_BLANK;
      o_dp         <= 1'b1;
      o_load_ready <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_digit      <= w_nextDigit;
      r_cnt        <= w_nextCnt;
      r_display    <= w_nextDisplay;
      r_dpReg      <= w_nextDpReg;
      r_pending    <= w_nextPending;
      r_pendDp     <= w_nextPendDp;
      r_pendFull   <= w_nextPendFull;
      o_anode      <= w_anode;
      o_segs       <= w_segs;
      o_dp         <= w_dp;
      o_load_ready <= !w_nextPendFull;
      o_frame_done <= w_frameDone;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_display_ctrl
// Self-checking bench for seven_seg_display_ctrl with CLK_DIV=4 and
// GHOST_CYCLES=2. A time-based reference model (cycles since scanning
// started, digit = t/6 mod 4) is compared every cycle, alongside directed
// table vectors and hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_seven_seg_display_ctrl;

  localparam int CD    = 4;
  localparam int GC    = 2;
  localparam int DIG   = CD + GC;
  localparam int FRAME = 4 * DIG;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] valueIn;
  logic        loadValid;
  logic        loadReady;
  logic [3:0]  dpIn;
  logic        blankLz;
  logic [3:0]  anode;
  logic [6:0]  segs;
  logic        dp;
  logic        frameDone;

  int checks = 0;
  int errors = 0;

  // Stimulus values applied on the next clock
  logic        tEn, tValid, tBlank;
  logic [15:0] tVal;
  logic [3:0]  tDp;

  // Reference model state
  logic        mScanning, mPendFull, mFd, mDp, mReady;
  int          mT;
  logic [15:0] mDisp, mPend;
  logic [3:0]  mDpReg, mPendDp, mAnode;
  logic [6:0]  mSegs;

  logic [6:0] refGlyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dpv;
    logic             blank;
    logic [3:0]       litMask;
    logic [3:0][6:0]  segsExp;
    logic [3:0]       dpOut;
  } vec_t;

  vec_t vecs [5];

  seven_seg_display_ctrl #(.CLK_DIV(CD), .GHOST_CYCLES(GC)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_value_in   (valueIn),
    .i_load_valid (loadValid),
    .o_load_ready (loadReady),
    .i_dp_in      (dpIn),
    .i_blank_lz   (blankLz),
    .o_anode      (anode),
    .o_segs       (segs),
    .o_dp         (dp),
    .o_frame_done (frameDone)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mScanning = 1'b0; mT = 0; mDisp = '0; mDpReg = '0; mPend = '0; mPendDp = '0;
    mPendFull = 1'b0; mFd = 1'b0; mAnode = 4'hF; mSegs = 7'h7F; mDp = 1'b1; mReady = 1'b1;
  endtask

  // Reference behaviour for one clock, from the rules of the display:
  // commit, then load, then scan timing from elapsed cycles.
  task automatic modelStep();
    logic        commit, accept, lit;
    int          d, ph;
    logic [15:0] sh;
    commit = mPendFull && (!mScanning || mFd);
    accept = tValid && (!mPendFull || commit);
    if (commit) begin
      mDisp = mPend; mDpReg = mPendDp; mPendFull = 1'b0;
    end
    if (accept) begin
      mPend = tVal; mPendDp = tDp; mPendFull = 1'b1;
    end
    if (!tEn) mScanning = 1'b0;
    else if (!mScanning) begin
      mScanning = 1'b1; mT = 0;
    end else mT++;
    mAnode = 4'hF; mSegs = 7'h7F; mDp = 1'b1; mFd = 1'b0;
    if (mScanning) begin
      d   = (mT / DIG) % 4;
      ph  = mT % DIG;
      sh  = mDisp >> (4 * d);
      lit = (ph < CD) && !(tBlank && (d != 0) && (sh == 16'h0));
      if (lit) begin
        mAnode = ~(4'b0001 << d);
        mSegs  = refGlyph[sh[3:0]];
        mDp    = ~mDpReg[d];
      end
      mFd = ((mT % FRAME) == FRAME - 1);
    end
    mReady = !mPendFull;
  endtask

  task automatic checkOutput();
    checkVal("cycle", {19'd0, anode, segs, dp, loadReady, frameDone},
                      {19'd0, mAnode, mSegs, mDp, mReady, mFd});
  endtask

  // Drive one clock of stimulus, advance the model and compare after the edge
  task automatic applyStimulus();
    enable = tEn; loadValid = tValid; valueIn = tVal; dpIn = tDp; blankLz = tBlank;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitAnode(input logic [3:0] a, input string name);
    for (int i = 0; i < 60; i++) begin
      if (anode == a) break;
      applyStimulus();
    end
    checkVal(name, anode, a);
  endtask

  task automatic waitFrameDone(input string name);
    for (int i = 0; i < 60; i++) begin
      if (frameDone) break;
      applyStimulus();
    end
    checkVal(name, frameDone, 1'b1);
  endtask

  task automatic loadIdle(input logic [15:0] v, input logic [3:0] dv);
    tEn = 1'b0; tValid = 1'b0;
    applyStimulus();
    tValid = 1'b1; tVal = v; tDp = dv;
    applyStimulus();
    tValid = 1'b0;
    applyStimulus();
  endtask

  logic [3:0]  litA [4];
  logic [6:0]  litS [4];
  logic [6:0]  newS [4];
  logic [3:0]  expA [FRAME];
  logic [6:0]  expS [FRAME];
  logic [3:0]  seen;
  logic [6:0]  segAt [4];
  logic        dpAt [4];
  logic [15:0] masks [5];

  initial begin
    litA = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    litS = '{7'h19, 7'h30, 7'h24, 7'h79};
    newS = '{7'h21, 7'h46, 7'h03, 7'h08};
    masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0F0F};
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < DIG; k++) begin
        expA[d*DIG+k] = (k < CD) ? litA[d] : 4'hF;
        expS[d*DIG+k] = (k < CD) ? litS[d] : 7'h7F;
      end
    vecs[0] = '{16'h0050, 4'h0, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[1] = '{16'h0000, 4'h0, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0050, 4'h0, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
    vecs[3] = '{16'hABCD, 4'hA, 1'b1, 4'b1111, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0101};
    vecs[4] = '{16'h0F00, 4'h1, 1'b1, 4'b0111, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1110};

    tEn = 1'b0; tValid = 1'b0; tVal = '0; tDp = '0; tBlank = 1'b0;
    enable = 1'b0; loadValid = 1'b0; valueIn = '0; dpIn = '0; blankLz = 1'b0;
    reset = 1'b1;
    modelReset();
    #13;
    $display("[TB] reset values");
    checkVal("rstAnode", anode, 4'hF);
    checkVal("rstSegs", segs, 7'h7F);
    checkVal("rstDp", dp, 1'b1);
    checkVal("rstReady", loadReady, 1'b1);
    checkVal("rstFd", frameDone, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] basic scan of 1234");
    loadIdle(16'h1234, 4'h0);
    tEn = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus();
      checkVal("seqAnode", anode, expA[i % FRAME]);
      checkVal("seqSegs", segs, expS[i % FRAME]);
      checkVal("seqFd", frameDone, (i % FRAME) == FRAME - 1);
    end

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++) begin
      tBlank = vecs[v].blank;
      loadIdle(vecs[v].value, vecs[v].dpv);
      tEn = 1'b1;
      seen = '0;
      for (int i = 0; i < FRAME; i++) begin
        applyStimulus();
        for (int k = 0; k < 4; k++)
          if (anode == ~(4'b0001 << k)) begin
            seen[k] = 1'b1; segAt[k] = segs; dpAt[k] = dp;
          end
      end
      checkVal("vecLitMask", seen, vecs[v].litMask);
      for (int k = 0; k < 4; k++)
        if (vecs[v].litMask[k]) begin
          checkVal("vecSegs", segAt[k], vecs[v].segsExp[k]);
          checkVal("vecDp", dpAt[k], vecs[v].dpOut[k]);
        end
    end
    tBlank = 1'b0;

    $display("[TB] mid-frame load");
    loadIdle(16'h1234, 4'h0);
    tEn = 1'b1;
    for (int i = 0; i < 9; i++) applyStimulus();
    tValid = 1'b1; tVal = 16'hABCD;
    applyStimulus();
    checkVal("readyDrop", loadReady, 1'b0);
    tVal = 16'h5555;
    applyStimulus();
    applyStimulus();
    tValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      for (int k = 0; k < 4; k++)
        if (anode == litA[k]) checkVal("oldFrame", segs, litS[k]);
      if (frameDone) break;
    end
    checkVal("fdSeen", frameDone, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus();
      if (i == 0) checkVal("readyBack", loadReady, 1'b1);
      for (int k = 0; k < 4; k++)
        if (anode == litA[k]) checkVal("newFrame", segs, newS[k]);
    end

    $display("[TB] load on frame_done while full");
    tValid = 1'b1; tVal = 16'h1111;
    applyStimulus();
    tVal = 16'h2222;
    applyStimulus();
    waitFrameDone("fdWhileFull");
    applyStimulus();
    tValid = 1'b0;
    checkVal("keepFull", loadReady, 1'b0);
    waitAnode(4'b1110, "firstDigitAfterCommit");
    checkVal("committedOld", segs, 7'h79);
    waitFrameDone("fdSecond");
    applyStimulus();
    checkVal("readyAfter2nd", loadReady, 1'b1);
    waitAnode(4'b1110, "firstDigitAfter2nd");
    checkVal("committedNew", segs, 7'h24);

    $display("[TB] enable drop during digit 2");
    waitAnode(4'b1011, "reachDigit2");
    tEn = 1'b0;
    applyStimulus();
    checkVal("disAnode", anode, 4'hF);
    checkVal("disSegs", segs, 7'h7F);
    applyStimulus();
    applyStimulus();
    tEn = 1'b1;
    applyStimulus();
    checkVal("reEnAnode", anode, 4'b1110);

    $display("[TB] async reset mid-cycle");
    tValid = 1'b1; tVal = 16'h9999;
    applyStimulus();
    tValid = 1'b0;
    applyStimulus();
    checkVal("fullBeforeRst", loadReady, 1'b0);
    waitAnode(4'b1110, "litBeforeRst");
    #2 reset = 1'b1;
    #1;
    checkVal("asyncAnode", anode, 4'hF);
    checkVal("asyncSegs", segs, 7'h7F);
    checkVal("asyncReady", loadReady, 1'b1);
    checkVal("asyncDp", dp, 1'b1);
    #2 reset = 1'b0;
    modelReset();
    applyStimulus();
    checkVal("postRstAnode", anode, 4'b1110);
    checkVal("postRstSegs", segs, 7'h40);

    $display("[TB] random stimulus");
    for (int i = 0; i < 500; i++) begin
      tEn    = ($urandom_range(0, 19) != 0);
      tValid = ($urandom_range(0, 3) == 0);
      tVal   = 16'($urandom) & masks[$urandom_range(0, 4)];
      tDp    = 4'($urandom);
      tBlank = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
